// File: rtl/score_disp.sv
// Score display: clamps and converts the score to BCD, then draws four 8x16 digits.
// Build option SCORE_LZB_EN blanks leading zero digits; the units digit always shows.
module score_disp #(
    parameter int          POS_X     = 520,
    parameter int          POS_Y     = 16,
    parameter logic [11:0] DIGIT_RGB = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] score,
    input  logic        new_score,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [15:0] bcd,
    output logic        busy,
    output logic        score_on,
    output logic [11:0] rgb_out
);

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    localparam logic [9:0] PX = 10'(POS_X);
    localparam logic [9:0] PY = 10'(POS_Y);

    state_t      state, state_nx;
    logic        capture;
    logic [13:0] bin;
    logic [15:0] acc, acc_adj;
    logic [3:0]  cnt;
    logic        pending;

    function automatic logic [13:0] clamp(input logic [13:0] s);
        return (s > 14'd9999) ? 14'd9999 : s;
    endfunction

    function automatic logic [7:0] glyph_row(input logic [3:0] d,
                                             input logic [3:0] r);
        logic [127:0] g;
        case (d)
            4'd0: g = 128'h003C6666_6E766666_6666663C_00000000;
            4'd1: g = 128'h00183878_18181818_18187E00_00000000;
            4'd2: g = 128'h003C6606_060C1830_60607E00_00000000;
            4'd3: g = 128'h003C6606_061C0606_06663C00_00000000;
            4'd4: g = 128'h000C1C3C_6CCCFE0C_0C0C1E00_00000000;
            4'd5: g = 128'h007E6060_607C0606_06663C00_00000000;
            4'd6: g = 128'h001C3060_607C6666_66663C00_00000000;
            4'd7: g = 128'h007E6606_0C181830_30303000_00000000;
            4'd8: g = 128'h003C6666_663C6666_66663C00_00000000;
            4'd9: g = 128'h003C6666_663E0606_0C383000_00000000;
            default: g = '0;
        endcase
        g = g << {r, 3'b000};
        return g[127:120];
    endfunction

    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (new_score) begin
                    capture  = 1'b1;
                    state_nx = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt == 4'd13) state_nx = LOAD;
            end
            LOAD: begin
                if (pending || new_score) begin
                    capture  = 1'b1;
                    state_nx = CONVERT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin     <= '0;
            acc     <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            bcd     <= '0;
            busy    <= 1'b0;
        end else begin
            if (capture) begin
                bin     <= clamp(score);
                acc     <= '0;
                cnt     <= '0;
                pending <= 1'b0;
                busy    <= 1'b1;
            end else if (state == CONVERT) begin
                acc <= {acc_adj[14:0], bin[13]};
                bin <= {bin[12:0], 1'b0};
                cnt <= cnt + 4'd1;
                if (new_score) pending <= 1'b1;
            end else if (state == LOAD) begin
                busy <= 1'b0;
            end
            if (state == LOAD) bcd <= acc;
        end
    end

    logic [9:0] dx, dy;
    logic       in_field, blank, lit;
    logic [3:0] nib;
    logic [7:0] row;

    assign dx = x - PX;
    assign dy = y - PY;
    assign in_field = (x >= PX) && (dx < 10'd32) && (y >= PY) && (dy < 10'd16);

    always_comb begin
        case (dx[4:3])
            2'd0:    nib = bcd[15:12];
            2'd1:    nib = bcd[11:8];
            2'd2:    nib = bcd[7:4];
            default: nib = bcd[3:0];
        endcase
    end

`ifdef SCORE_LZB_EN
    always_comb begin
        case (dx[4:3])
            2'd0:    blank = (bcd[15:12] == 4'd0);
            2'd1:    blank = (bcd[15:8] == 8'd0);
            2'd2:    blank = (bcd[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign row = glyph_row(nib, dy[3:0]);
    assign lit = in_field && !blank && (nib <= 4'd9) && row[3'd7 - dx[2:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score_on <= 1'b0;
            rgb_out  <= '0;
        end else begin
            score_on <= lit;
            rgb_out  <= lit ? DIGIT_RGB : 12'h000;
        end
    end

endmodule

// File: tb/tb_score_disp.sv
// Bench for score_disp: scoreboarded conversions plus a glyph sweep of the field.
module tb_score_disp;

    localparam int PX = 520;
    localparam int PY = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] score = '0;
    logic        new_score = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [15:0] bcd;
    logic        busy;
    logic        score_on;
    logic [11:0] rgb_out;

    int passed = 0;
    int total = 0;
    logic [15:0] sb[$];

    score_disp #(.POS_X(PX), .POS_Y(PY), .DIGIT_RGB(12'hFFF)) dut (
        .clk(clk), .reset(reset), .score(score), .new_score(new_score),
        .x(x), .y(y), .bcd(bcd), .busy(busy),
        .score_on(score_on), .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] glyph(input logic [3:0] d, input int r);
        logic [127:0] g;
        case (d)
            4'd0: g = 128'h003C6666_6E766666_6666663C_00000000;
            4'd1: g = 128'h00183878_18181818_18187E00_00000000;
            4'd2: g = 128'h003C6606_060C1830_60607E00_00000000;
            4'd3: g = 128'h003C6606_061C0606_06663C00_00000000;
            4'd4: g = 128'h000C1C3C_6CCCFE0C_0C0C1E00_00000000;
            4'd5: g = 128'h007E6060_607C0606_06663C00_00000000;
            4'd6: g = 128'h001C3060_607C6666_66663C00_00000000;
            4'd7: g = 128'h007E6606_0C181830_30303000_00000000;
            4'd8: g = 128'h003C6666_663C6666_66663C00_00000000;
            4'd9: g = 128'h003C6666_663E0606_0C383000_00000000;
            default: g = '0;
        endcase
        return g[127-8*r -: 8];
    endfunction

    function automatic logic exp_pix(input int px, input int py,
                                     input logic [15:0] v);
        int dxi, dyi, di;
        logic [3:0] n;
        logic [7:0] r;
        logic lz;
        if (px < PX || px >= PX + 32 || py < PY || py >= PY + 16) return 1'b0;
        dxi = px - PX;
        dyi = py - PY;
        di = dxi / 8;
        n = v[15-4*di -: 4];
        lz = 1'b0;
`ifdef SCORE_LZB_EN
        lz = (di < 3) && ((v >> (12 - 4*di)) == 16'd0);
`endif
        if (lz || n > 4'd9) return 1'b0;
        r = glyph(n, dyi);
        return r[7 - (dxi % 8)];
    endfunction

    task automatic pulse(input logic [13:0] v);
        @(negedge clk);
        score = v;
        new_score = 1'b1;
        @(negedge clk);
        new_score = 1'b0;
    endtask

    task automatic run_conv(input string tag, input logic [13:0] v,
                            input logic [15:0] e);
        sb.push_back(e);
        pulse(v);
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk({tag, "_bcd"}, 32'(bcd), 32'(sb.pop_front()));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic pix(input string tag, input int px, input int py);
        logic e;
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        e = exp_pix(px, py, bcd);
        @(negedge clk);
        chk({tag, "_on"}, 32'(score_on), 32'(e));
        chk({tag, "_rgb"}, 32'(rgb_out), e ? 32'hFFF : 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_on", 32'(score_on), 32'd0);
        chk("rst_rgb", 32'(rgb_out), 32'h0);
        reset = 1'b1;
        pix("rst_pix", PX + 1, PY + 4);
`ifndef SCORE_LZB_EN
        chk("rst_pix_lit", 32'(score_on), 32'd1);
`endif

        run_conv("c9999", 14'd9999, 16'h9999);
        run_conv("c8191", 14'd8191, 16'h8191);
        run_conv("clamp", 14'd12000, 16'h9999);

        sb.push_back(16'h0040);
        pulse(14'd40);
        chk("col_busy0", 32'(busy), 32'd1);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 4) begin
                score = 14'd560;
                new_score = 1'b1;
                sb.push_back(16'h0560);
            end
            if (k == 5) new_score = 1'b0;
            if (k < 30) chk("col_busy", 32'(busy), 32'd1);
            if (k == 15) chk("col_bcd1", 32'(bcd), 32'(sb.pop_front()));
            if (k == 30) begin
                chk("col_bcd2", 32'(bcd), 32'(sb.pop_front()));
                chk("col_idle", 32'(busy), 32'd0);
            end
        end

        run_conv("c20", 14'd20, 16'h0020);
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 32; xx++)
                pix("sweep", PX + xx, PY + yy);
        pix("left", PX - 1, PY + 4);
        pix("right", PX + 32, PY + 4);
        pix("below", PX + 1, PY + 16);
        chk("below_off", 32'(score_on), 32'd0);

        sb.push_back(16'h0500);
        pulse(14'd500);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_bcd", 32'(bcd), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_bcd", 32'(bcd), 32'h0);
        run_conv("c7", 14'd7, 16'h0007);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/score_disp.md
Name: score_disp

Overview:
- Consumer end of the score interface driven by the egg/score controller.
- Captures the 14-bit binary `score` on each `new_score` pulse and converts it to 4-digit BCD with a sequential double-dabble engine (one bit per clock).
- Holds the displayed value and renders it as four 8x16 glyph digits at a fixed screen position, returning a pixel-on flag and a colour for the VGA mixer.

Parameters:
- POS_X, 520, left pixel column of the digit field.
- POS_Y, 16, top pixel row of the digit field.
- DIGIT_RGB, 12'hFFF, colour driven on `rgb_out` for lit glyph pixels.

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-low reset
- score  in  14  binary score, nominal range 0..9999
- new_score  in  1  one-cycle pulse; `score` is already valid in the same cycle
- x  in  10  current pixel column
- y  in  10  current pixel row
- bcd  out  16  displayed value, 4 BCD digits, [15:12] = thousands
- busy  out  1  conversion in progress
- score_on  out  1  current pixel belongs to a lit glyph pixel
- rgb_out  out  12  DIGIT_RGB when `score_on`, else 12'h000

Behaviour:
- Reset (reset=0, asynchronous) sets: state IDLE, `bcd`=16'h0000, `busy`=0, pending flag 0, iteration counter 0, `score_on`=0, `rgb_out`=0.
- Reset mid-conversion aborts the conversion; `bcd` reads 0000.
- FSM states: IDLE, CONVERT, LOAD.
- IDLE:
  - On an edge with `new_score`=1: capture score into a 14-bit shift register.
  - If `score` > 9999, capture 9999 instead (clamp).
  - Clear the 16-bit BCD accumulator and counter; go to CONVERT; `busy`<=1.
- CONVERT (14 edges):
  - Each edge, add 3 to every accumulator nibble that is >= 5.
  - Then shift {accumulator, binary} left by one.
  - Counter increments; after the 14th shift go to LOAD.
- LOAD (1 edge):
  - `bcd` <= accumulator.
  - If pending=1 or `new_score`=1 on this edge: re-capture current `score` (clamped), clear pending, go to CONVERT, `busy` stays 1.
  - Otherwise go to IDLE, `busy`<=0.
- Latency: pulse sampled at edge E0 gives `bcd` updated at edge E15 and `busy` low after E15 (if nothing is pending).
- `new_score` sampled while in CONVERT sets pending=1. Multiple pulses collapse to one. The value converted next is whatever `score` holds at the LOAD edge, i.e. the latest value.
- `bcd` changes only in LOAD; it never shows partial results.
- Rendering:
  - Field spans x in [POS_X, POS_X+32) and y in [POS_Y, POS_Y+16).
  - dx = x-POS_X; digit index = dx[4:3] (0 = thousands); glyph column = dx[2:0], MSB leftmost; glyph row = (y-POS_Y)[3:0].
  - Glyphs 0-9 come from an internal 10x16x8 ROM. BCD nibbles 10-15 render blank.
  - `score_on` and `rgb_out` are registered: valid one clock after the `x`,`y` they correspond to.
  - Outside the field: `score_on`=0, `rgb_out`=0.
  - Rendering reads only `bcd`.
- Arithmetic: all subtractions are 10-bit unsigned; the out-of-field test is done before indexing, so wrap-around never selects a glyph.

Optional Feature:
- Macro SCORE_LZB_EN.
- Defined: leading zeros are blanked. A digit renders blank if it is 0 and all more-significant digits are 0. The units digit always renders, so the value 0 shows "0" and 20 shows "20".
- Undefined: all four digits always render, so 0 shows "0000" and 20 shows "0020".
- `bcd` output is identical in both cases.

Test Plan:
- Reset: hold reset=0, then release -> `bcd`=16'h0000, `busy`=0, `score_on`=0, `rgb_out`=12'h000; pixel (POS_X+1, POS_Y+4) shows glyph "0" pixels (without SCORE_LZB_EN).
- Basic conversion: `score`=20 with a one-cycle `new_score` -> `busy` high for 15 cycles; `bcd`=16'h0020 at E15. Repeat with 9999 -> 16'h9999, and 8191 -> 16'h8191.
- Clamp: `score`=12000 with a pulse -> `bcd`=16'h9999.
- Collision: pulse with `score`=40; at E5 pulse with `score`=560 -> `bcd`=16'h0040 at E15, then 16'h0560 at E30; `busy` continuous 1 from E0 to E30.
- Render: `bcd`=16'h0020; sweep the field -> `score_on` matches the ROM bitmaps for 0,0,2,0 with one-cycle delay and `rgb_out`=DIGIT_RGB when lit. Pixels at x=POS_X-1, x=POS_X+32 and y=POS_Y+16 -> `score_on`=0.
- Reset mid-conversion: pulse with `score`=500, assert reset at E7 -> `bcd`=16'h0000, `busy`=0 immediately. After release the FSM is IDLE and stays idle until the next pulse.
